// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment bit order, glyph constants and
// the event record width. Optional feature macro: SEVEN_SEG_CAPTURE_DP_EN.
package seven_seg_pkg;

  // Segment bit positions on the 7-bit segment bus (active-high)
  localparam int unsigned SEG_A = 0;
  localparam int unsigned SEG_B = 1;
  localparam int unsigned SEG_C = 2;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 4;
  localparam int unsigned SEG_F = 5;
  localparam int unsigned SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h67;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Glyph table indexed by the nibble it encodes
  localparam logic [6:0] SEG_GLYPHS [16] = '{
    SEG_HEX_0, SEG_HEX_1, SEG_HEX_2, SEG_HEX_3,
    SEG_HEX_4, SEG_HEX_5, SEG_HEX_6, SEG_HEX_7,
    SEG_HEX_8, SEG_HEX_9, SEG_HEX_A, SEG_HEX_B,
    SEG_HEX_C, SEG_HEX_D, SEG_HEX_E, SEG_HEX_F
  };

  // Event record: {dp, valid, nibble} with dp, {valid, nibble} without
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  localparam int unsigned EVT_W = 6;
`else
  localparam int unsigned EVT_W = 5;
`endif

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational glyph decoder: exact match of a 7-bit segment pattern
// against the hex glyph table; anything else (including blank) is illegal.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic [3:0] nibble
);

  // Table search; at most one entry can match since glyphs are distinct
  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (seg == SEG_GLYPHS[i]) begin
        legal  = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Seven-segment bus capture: synchronizes the multiplexed display bus,
// filters scan ghosting with a stability counter, decodes committed glyphs
// per digit and reports per-digit changes on a valid/ready event port.
// Optional feature macro: SEVEN_SEG_CAPTURE_DP_EN (decimal point capture).
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter bit          AN_ACTIVE_LOW = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [DIGITS-1:0]         i_an,
  input  logic [6:0]                i_seg,
  output logic [4*DIGITS-1:0]       o_digits,
  output logic [DIGITS-1:0]         o_valid,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [$clog2(DIGITS)-1:0] o_evt_digit,
  output logic [EVT_W-1:0]          o_evt_value
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  ,
  input  logic                      i_dp,
  output logic [DIGITS-1:0]         o_dp
`endif
);

  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [DIGITS-1:0] AN_IDLE = {DIGITS{AN_ACTIVE_LOW}};

  logic [DIGITS-1:0] an_s1, an_s2, an_act;
  logic [6:0]        seg_s1, seg_s2;
  logic [CW-1:0]     cnt;
  logic              same, onehot, commit;
  logic [IW-1:0]     sel, pick;
  logic              legal, found, load;
  logic [3:0]        nib, new_nib;
  logic [EVT_W-1:0]  cur_rec, new_rec, snap;
  logic [DIGITS-1:0] dirty, dirty_set, dirty_clr;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
  logic              dp_s1, dp_s2;
`endif

  seven_seg_decode u_decode (
    .seg    (seg_s2),
    .legal  (legal),
    .nibble (nib)
  );

  // Two-stage input synchronizer; anodes reset to their deasserted level
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_s1  <= AN_IDLE;
      an_s2  <= AN_IDLE;
      seg_s1 <= '0;
      seg_s2 <= '0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      dp_s1  <= 1'b0;
      dp_s2  <= 1'b0;
`endif
    end else begin
      an_s1  <= i_an;
      an_s2  <= an_s1;
      seg_s1 <= i_seg;
      seg_s2 <= seg_s1;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      dp_s1  <= i_dp;
      dp_s2  <= dp_s1;
`endif
    end
  end

  // Stability compare, digit select and commit record construction.
  // s1 is the value s2 is about to take, so comparing s1 with s2 is the
  // s2-versus-previous compare made one edge earlier, meeting the latency.
  always_comb begin
    an_act = an_s2 ^ AN_IDLE;
    onehot = $onehot(an_act);
    same   = (an_s1 == an_s2) && (seg_s1 == seg_s2);
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    same   = same && (dp_s1 == dp_s2);
`endif
    commit = same && onehot && (cnt == CW'(STABLE_CYCLES - 1));

    sel = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (an_act[i]) sel = IW'(i);
    end

    new_nib = legal ? nib : o_digits[4*sel +: 4];
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    cur_rec = {o_dp[sel], o_valid[sel], o_digits[4*sel +: 4]};
    new_rec = {dp_s2, legal, new_nib};
`else
    cur_rec = {o_valid[sel], o_digits[4*sel +: 4]};
    new_rec = {legal, new_nib};
`endif
    dirty_set = (commit && (new_rec != cur_rec)) ? an_act : '0;
  end

  // Lowest-index dirty digit selection for the event loader
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      if (dirty[i-1]) begin
        found = 1'b1;
        pick  = IW'(i - 1);
      end
    end
    load = !o_evt_valid || i_evt_ready;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    snap = {o_dp[pick], o_valid[pick], o_digits[4*pick +: 4]};
`else
    snap = {o_valid[pick], o_digits[4*pick +: 4]};
`endif
    dirty_clr = (load && found) ? (DIGITS'(1) << pick) : '0;
  end

  // Stability counter, saturating so each stable window commits once
  always_ff @(posedge i_clk) begin
    if (i_rst || !(same && onehot)) begin
      cnt <= '0;
    end else if (cnt != CW'(STABLE_CYCLES)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Per-digit storage and dirty flags; a same-edge set wins over the clear
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_digits <= '0;
      o_valid  <= '0;
      dirty    <= '0;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
      o_dp     <= '0;
`endif
    end else begin
      if (commit) begin
        o_digits[4*sel +: 4] <= new_nib;
        o_valid[sel]         <= legal;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        o_dp[sel]            <= dp_s2;
`endif
      end
      dirty <= (dirty & ~dirty_clr) | dirty_set;
    end
  end

  // Event output register; holds while presented and not accepted
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_evt_valid <= 1'b0;
      o_evt_digit <= '0;
      o_evt_value <= '0;
    end else if (load) begin
      o_evt_valid <= found;
      if (found) begin
        o_evt_digit <= pick;
        o_evt_value <= snap;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Self-checking bench for seven_seg_capture (DIGITS=4, STABLE_CYCLES=4,
// active-low anodes, default build without decimal point capture).
module tb_seven_seg_capture;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b0;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h00;
  logic [15:0] digits;
  logic [3:0]  valid;
  logic        evv;
  logic [1:0]  evd;
  logic [4:0]  evx;

  seven_seg_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (S),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_an        (an),
    .i_seg       (seg),
    .o_digits    (digits),
    .o_valid     (valid),
    .o_evt_valid (evv),
    .i_evt_ready (rdy),
    .o_evt_digit (evd),
    .o_evt_value (evx)
  );

  always #5 clk = ~clk;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h67, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, exp);
  endtask

  // Active-low anode pattern -> digit index, -1 unless exactly one selected
  function automatic int an_index(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a == ~(4'b0001 << i)) return i;
    return -1;
  endfunction

  function automatic int glyph_val(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (glyph[i] == s) return i;
    return -1;
  endfunction

  // Behavioural model: a commit happens one edge after the (S+1)th identical
  // sample of a single-digit input; events follow the dirty-set rules.
  logic [3:0]  m_dig [4];
  bit          m_val [4];
  bit   [3:0]  m_dirty, setm;
  bit          m_evv, m_on = 1'b0, load_m;
  int          m_evd, pick, d, g, run;
  logic [4:0]  m_evx, snap, old;
  logic [10:0] last;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin m_dig[i] = 4'h0; m_val[i] = 1'b0; end
      m_dirty = '0; m_evv = 1'b0; m_evd = 0; m_evx = '0;
      last = {4'hF, 7'h00}; run = 1; m_on = 1'b1;
    end else if (m_on) begin
      load_m = !m_evv || rdy;
      pick = -1;
      for (int i = 0; i < 4; i++) if (m_dirty[i] && pick < 0) pick = i;
      if (pick >= 0) snap = {m_val[pick], m_dig[pick]};
      setm = '0;
      d = an_index(last[10:7]);
      if (run == S + 1 && d >= 0) begin
        old = {m_val[d], m_dig[d]};
        g = glyph_val(last[6:0]);
        if (g >= 0) begin m_dig[d] = 4'(g); m_val[d] = 1'b1; end
        else m_val[d] = 1'b0;
        if ({m_val[d], m_dig[d]} != old) setm[d] = 1'b1;
      end
      if (load_m) begin
        m_evv = (pick >= 0);
        if (pick >= 0) begin m_evd = pick; m_evx = snap; m_dirty[pick] = 1'b0; end
      end
      m_dirty |= setm;
      if ({an, seg} == last) begin
        if (run < 1000) run++;
      end else begin
        last = {an, seg};
        run = 1;
      end
    end
  end

  // Every-cycle comparison against the model
  logic [15:0] e_dig;
  logic [3:0]  e_val;
  always @(negedge clk) begin
    if (m_on) begin
      for (int i = 0; i < 4; i++) begin e_dig[4*i +: 4] = m_dig[i]; e_val[i] = m_val[i]; end
      chk("digits", digits, e_dig);
      chk("valid", valid, e_val);
      chk("evt_valid", evv, m_evv);
      if (m_evv) begin
        chk("evt_digit", evd, m_evd);
        chk("evt_value", evx, m_evx);
      end
    end
  end

  // Transferred events as digit*32 + {valid, nibble}
  int evq [$];
  always @(posedge clk) if (!rst && evv && rdy) evq.push_back(int'(evd) * 32 + int'(evx));

  task automatic chk_events(input string name, input int n, input int e0, input int e1,
                            input int e2, input int e3);
    int e [4];
    e = '{e0, e1, e2, e3};
    chk({name, "_count"}, evq.size(), n);
    for (int i = 0; i < n && i < evq.size(); i++) chk(name, evq[i], e[i]);
    evq.delete();
  endtask

  task automatic show(input int dg, input logic [6:0] s, input int n);
    an = ~(4'b0001 << dg);
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic blank(input int n);
    an = 4'hF;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_digits", digits, 16'h0);
    chk("rst_valid", valid, 4'h0);
    chk("rst_evt_valid", evv, 1'b0);
    rst = 1'b0;
    rdy = 1'b1;
    blank(2);

    // Clean scan
    show(0, 7'h3F, 8); show(1, 7'h06, 8); show(2, 7'h5B, 8); show(3, 7'h4F, 8);
    blank(6);
    chk("scan_digits", digits, 16'h3210);
    chk("scan_valid", valid, 4'hF);
    chk_events("scan", 4, 16, 49, 82, 115);

    // Ghost filter
    show(1, 7'h7F, 2);
    blank(10);
    chk("ghost_digits", digits, 16'h3210);
    chk_events("ghost", 0, 0, 0, 0, 0);

    // Commit latency and illegal glyph
    an = ~4'b0100;
    seg = 7'h7D;
    repeat (5) @(negedge clk);
    chk("lat_hold", digits[11:8], 4'h2);
    @(negedge clk);
    chk("lat_commit", digits[11:8], 4'h6);
    chk("lat_evt_idle", evv, 1'b0);
    @(negedge clk);
    chk("lat_evt", evv, 1'b1);
    repeat (5) @(negedge clk);
    blank(4);
    show(2, 7'h00, 8);
    blank(6);
    chk("illegal_nib", digits[11:8], 4'h6);
    chk("illegal_valid", valid[2], 1'b0);
    chk_events("illegal", 2, 86, 70, 0, 0);

    // Backpressure
    rdy = 1'b0;
    show(0, 7'h6D, 8); show(3, 7'h77, 8);
    blank(4);
    chk("bp_valid", evv, 1'b1);
    chk("bp_digit", evd, 2'd0);
    repeat (3) @(negedge clk);
    chk("bp_hold", evd, 2'd0);
    chk("bp_hold_val", evx, 5'h15);
    rdy = 1'b1;
    @(negedge clk);
    chk("bp_next", evd, 2'd3);
    chk("bp_next_valid", evv, 1'b1);
    @(negedge clk);
    chk("bp_drained", evv, 1'b0);
    chk_events("bp", 2, 21, 122, 0, 0);

    // Coalesce while stalled, then a commit on the load edge
    rdy = 1'b0;
    show(3, 7'h39, 8); show(0, 7'h06, 8); show(0, 7'h5B, 8); show(0, 7'h4F, 8);
    chk("co_stall_digit", evd, 2'd3);
    an = ~4'b0001;
    seg = 7'h7D;
    repeat (5) @(negedge clk);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    blank(6);
    chk_events("coalesce", 3, 124, 19, 22, 0);

    // Reset with events pending
    rdy = 1'b0;
    show(1, 7'h7F, 8); show(2, 7'h3F, 8);
    blank(2);
    chk("pre_rst_pending", evv, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_digits", digits, 16'h0);
    chk("mid_rst_valid", valid, 4'h0);
    chk("mid_rst_evt_valid", evv, 1'b0);
    chk("mid_rst_evt_digit", evd, 2'd0);
    chk("mid_rst_evt_value", evx, 5'h00);
    rst = 1'b0;
    rdy = 1'b1;
    blank(12);
    chk("post_rst_evt", evv, 1'b0);
    chk_events("reset", 0, 0, 0, 0, 0);

    // Randomized scan traffic checked by the model
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7) an = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 8) an = 4'hF;
      else an = 4'($urandom);
      if ($urandom_range(0, 3) != 0) seg = glyph[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 9)) @(negedge clk);
    end
    rdy = 1'b1;
    blank(20);
    chk("final_drained", evv, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side counterpart of the hex-to-seven-segment encoder. It samples a multiplexed seven-segment display bus (one-hot anode select plus shared segment lines), filters scan-transition ghosting, and decodes each digit's glyph back to a 4-bit hex value. It sits in the emulator/test harness between the design's display outputs and the host-side reporting logic. Per-digit value changes are reported through a valid/ready event port.

## Interface
- `DIGITS`, 4: number of multiplexed digits (≥2).
- `STABLE_CYCLES`, 16: consecutive identical samples required before a commit (≥2).
- `AN_ACTIVE_LOW`, 1: anode polarity; segments are always active-high, bit0=a … bit6=g.

Ports:
- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_an`  in  DIGITS  anode select; bit d selects digit d.
- `i_seg`  in  7  segment lines.
- `o_digits`  out  4*DIGITS  decoded nibble; digit d is at [4d+3:4d].
- `o_valid`  out  DIGITS  last committed pattern of digit d was a legal hex glyph.
- `o_evt_valid`  out  1  change event pending.
- `i_evt_ready`  in  1  consumer accepts event.
- `o_evt_digit`  out  $clog2(DIGITS)  digit index of the event.
- `o_evt_value`  out  5  {valid, nibble} snapshot of that digit.

## Operation
- **Input synchronization:** `i_an` and `i_seg` pass through two flop stages (s1, s2). Anodes are normalized to active-high after s2.
- **Stability filter:** a counter compares s2 with its previous value.
  - The counter clears when the pattern differs or the anodes are not exactly one-hot (zero or multiple bits set). Otherwise it increments, saturating at STABLE_CYCLES.
  - A commit occurs only on the increment to STABLE_CYCLES, so there is exactly one commit per stable window.
- **Decode:** exact match only.
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - Any other pattern, including blank 00, is illegal.
- **Commit to digit d:**
  - Legal glyph: nibble updates and `o_valid[d]`=1.
  - Illegal glyph: nibble holds its previous value and `o_valid[d]`=0.
  - If {valid, nibble} differs from the stored value, set `dirty[d]`.
- **Event port:**
  - When `o_evt_valid`=0, or when `o_evt_valid`&`i_evt_ready`, the output register loads the lowest-index dirty digit: index plus a snapshot of its stored {valid, nibble}. That dirty bit is cleared.
  - `o_evt_valid`=1 only if a dirty digit was loaded.
  - While `o_evt_valid`&!`i_evt_ready`, the index and value hold stable.
- **Simultaneous events:**
  - If a commit sets `dirty[d]` on the same edge that the loader clears it, the bit stays set, producing a later second event with the newer value.
  - Repeated changes to one digit before it is loaded coalesce into one event carrying the latest value.
- **Reset:**
  - Clears `o_digits`, `o_valid`, `dirty`, the counter, all sync flops (anodes deasserted), `o_evt_valid`, `o_evt_digit` and `o_evt_value`. All outputs are 0.
  - Reset mid-operation discards pending events; no event is produced for pre-reset content.

## Timing
- Inputs stable from edge N (first edge sampling the new value): commit, `o_digits`/`o_valid` update and `dirty` set occur at edge N+STABLE_CYCLES+1.
- `o_evt_valid` asserts at the following edge, N+STABLE_CYCLES+2, if the event register is free.
- Handshake: transfer on an edge with `o_evt_valid`&`i_evt_ready`. The next pending event is presented on that same edge, so back-to-back transfers run at one event per cycle.
- A pattern held for fewer than STABLE_CYCLES samples is never committed.

## Configuration
- `SEVEN_SEG_CAPTURE_DP_EN`: adds input `i_dp` (1 bit, decimal point) and output `o_dp` (DIGITS bits).
  - `i_dp` is synchronized with the segments and included in the stability compare.
  - `o_dp[d]` updates on every commit to digit d. A dp change sets `dirty[d]`, and `o_evt_value` widens to 6 bits as {dp, valid, nibble}.
- Without the macro: no dp ports; `o_evt_value` is 5 bits.

## Structure
- Shared package `seven_seg_pkg`:
  - the 16 glyph constants and `SEG_BLANK`;
  - the segment bit-order constants, used by both encoder and capture.
- Sub-module `seven_seg_decode`: combinational 7-bit pattern → {legal, nibble}, built from the package constants.

## Test plan
- **Clean scan:** DIGITS=4, STABLE_CYCLES=4, scan digits 0..3 showing 3F, 06, 5B, 4F for 8 cycles each → `o_digits`=16'h3210, `o_valid`=4'hF. Four events arrive in index order 0, 1, 2, 3.
- **Ghost filter:** 2-cycle glitch pattern 7F on digit 1 between scans → no commit and no event.
- **Illegal glyph:** digit 2 shows 7D then 00 → events {1,6} then {0,6}. The nibble stays 6.
- **Backpressure:** hold `i_evt_ready`=0 while digits 0 and 3 change → `o_evt_digit`=0 holds. After ready, digit 3 follows the next cycle.
- **Coalesce/collision:** digit 0 goes 1→2→3 while the event port is stalled → a single event {1,3}. Then a commit on the load edge → a second event.
- **Reset mid-stream:** assert `i_rst` with events pending → all outputs 0, and no event for pre-reset content after release.
